// File: rtl/cosine_datapath.sv
// cosine_datapath: Taylor-series cos(x) datapath paced by the controlUnit state word; RANGE_REDUCE_EN folds x into [-PI, PI].
// Latency 2*N+1 cycles from start to done for N terms; no backpressure, stop tells controlUnit when to finish.
module cosine_datapath #(
  parameter int DATA_W    = 18,
  parameter int FRAC_W    = 15,
  parameter int MAX_TERMS = 8,
  parameter int EPS       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               state,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     stop,
  output logic signed [DATA_W-1:0] cos_out,
  output logic [DATA_W-1:0]        err_out,
  output logic                     done
);

  // term and x2 carry 4 extra integer bits: x^2/2 reaches ~8 at |x| = 4
  localparam int TW = DATA_W + 4;
  localparam int RF = FRAC_W + 8;
  localparam int PW = 2 * TW;
  localparam int QW = PW + RF;

  localparam logic signed [TW-1:0] ONE     = TW'(longint'(1) << FRAC_W);
  localparam logic [3:0]           K_MAX   = 4'(MAX_TERMS);
  localparam logic [TW-1:0]        EPS_T   = TW'(EPS);
  localparam logic signed [TW:0]   SUM_MAX = (TW+1)'((longint'(1) << (DATA_W-1)) - 1);
  localparam logic signed [TW:0]   SUM_MIN = ~SUM_MAX;
  localparam logic [TW-1:0]        ERR_MAX = TW'((longint'(1) << DATA_W) - 1);

  typedef enum logic [3:0] {
    ST_STANDBY  = 4'd0,
    ST_ALERT    = 4'd1,
    ST_START    = 4'd2,
    ST_ACCUM    = 4'd3,
    ST_DIST     = 4'd4,
    ST_REMULT   = 4'd5
  } cu_state_e;

  // Reciprocals carry 8 guard bits so rounding of 1/12 and 1/30 does not bias the result by tens of LSBs
  function automatic logic [RF-1:0] recip_val(input int i);
    longint d;
    if (i < 1 || i >= MAX_TERMS) return '0;
    d = longint'(2*i - 1) * longint'(2*i);
    return RF'(((longint'(1) << RF) + d / 2) / d);
  endfunction

  cu_state_e                st;
  logic signed [DATA_W-1:0] x_r, x_red, sum, sum_next;
  logic signed [TW-1:0]     x2, term, term_next;
  logic [TW-1:0]            term_abs;
  logic [3:0]               k;
  logic [RF-1:0]            recip_rom [16];
  logic signed [2*DATA_W-1:0] xr_w;
  logic signed [PW-1:0]     term_w, x2_w, p1;
  logic signed [QW-1:0]     p1_w, rcp_w;
  logic signed [TW:0]       sum_wide;
  logic [DATA_W-1:0]        err_next;

  for (genvar i = 0; i < 16; i++) begin : g_rom
    assign recip_rom[i] = recip_val(i);
  end

`ifdef RANGE_REDUCE_EN
  localparam int XW = DATA_W + 4;
  localparam longint PI_Q     = ((64'sd3373259426 * (longint'(1) << FRAC_W)) + (longint'(1) << 29)) >>> 30;
  localparam longint TWO_PI_Q = ((64'sd6746518852 * (longint'(1) << FRAC_W)) + (longint'(1) << 29)) >>> 30;
  localparam logic signed [XW-1:0] PI_X     = XW'(PI_Q);
  localparam logic signed [XW-1:0] TWO_PI_X = XW'(TWO_PI_Q);

  logic signed [XW-1:0] x_ext;

  always_comb begin
    x_ext = XW'(x_in);
    if (x_ext > PI_X)
      x_red = DATA_W'(x_ext - TWO_PI_X);
    else if (x_ext < -PI_X)
      x_red = DATA_W'(x_ext + TWO_PI_X);
    else
      x_red = x_in;
  end
`else
  assign x_red = x_in;
`endif

  assign st       = cu_state_e'(state);
  assign xr_w     = (2*DATA_W)'(x_r);
  assign term_abs = term[TW-1] ? -term : term;
  assign stop     = (k == 4'd0) | (term_abs < EPS_T) | (k == K_MAX);

  assign term_w    = PW'(term);
  assign x2_w      = PW'(x2);
  assign p1        = (term_w * x2_w) >>> FRAC_W;
  assign p1_w      = QW'(p1);
  assign rcp_w     = $signed(QW'(recip_rom[k]));
  assign term_next = TW'((-(p1_w * rcp_w)) >>> RF);

  assign sum_wide = (TW+1)'(sum) + (TW+1)'(term);
  assign sum_next = (sum_wide > SUM_MAX) ? SUM_MAX[DATA_W-1:0] :
                    (sum_wide < SUM_MIN) ? SUM_MIN[DATA_W-1:0] : sum_wide[DATA_W-1:0];
  assign err_next = (term_abs > ERR_MAX) ? '1 : term_abs[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      x_r     <= '0;
      x2      <= '0;
      term    <= '0;
      sum     <= '0;
      k       <= '0;
      cos_out <= '0;
      err_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        ST_START: begin
          x_r  <= x_red;
          term <= ONE;
          sum  <= '0;
          k    <= 4'd1;
        end
        // x2 is squared from the registered angle here, one stage ahead of the first remult
        ST_ACCUM: begin
          sum <= sum_next;
          x2  <= TW'((xr_w * xr_w) >>> FRAC_W);
        end
        ST_DIST: begin
          cos_out <= sum;
          err_out <= err_next;
          done    <= 1'b1;
        end
        ST_REMULT: begin
          term <= term_next;
          k    <= k + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cosine_datapath.sv
// Self-checking bench for cosine_datapath: acts as controlUnit and compares against a reference Taylor model.
module tb_cosine_datapath;

  localparam int     DATA_W    = 18;
  localparam int     FRAC_W    = 15;
  localparam int     MAX_TERMS = 8;
  localparam int     EPS       = 2;
  localparam longint ONE       = 32768;
  localparam longint PI_Q      = 102944;
  localparam longint TWO_PI_Q  = 205887;
  localparam longint RSCALE    = longint'(1) << (FRAC_W + 8);

  logic                     clk = 1'b0;
  logic                     rst;
  logic [3:0]               state;
  logic signed [DATA_W-1:0] x_in;
  logic                     stop, stop0;
  logic signed [DATA_W-1:0] cos_out, cos0;
  logic [DATA_W-1:0]        err_out, err0;
  logic                     done, done0;

  int n_checks = 0;
  int n_pass   = 0;

  cosine_datapath #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .MAX_TERMS(MAX_TERMS), .EPS(EPS)) dut (
    .clk(clk), .rst(rst), .state(state), .x_in(x_in),
    .stop(stop), .cos_out(cos_out), .err_out(err_out), .done(done)
  );

  cosine_datapath #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .MAX_TERMS(MAX_TERMS), .EPS(0)) dut_e0 (
    .clk(clk), .rst(rst), .state(state), .x_in(x_in),
    .stop(stop0), .cos_out(cos0), .err_out(err0), .done(done0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint diff;
    n_checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint labs(input longint a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic longint recip(input int k);
    real r;
    r = real'(RSCALE) / real'((2*k - 1) * (2*k));
    return longint'($rtoi(r + 0.5));
  endfunction

  // Reference: sum (-1)^k x^2k/(2k)! built term by term with floor division and a saturating sum
  task automatic model(input longint x, input longint eps, output longint c, output longint e, output int n);
    longint xr, x2, term, sum, smax;
    smax = (longint'(1) << (DATA_W-1)) - 1;
    xr = x;
`ifdef RANGE_REDUCE_EN
    if (x > PI_Q) xr = x - TWO_PI_Q;
    else if (x < -PI_Q) xr = x + TWO_PI_Q;
`endif
    x2 = fdiv(xr * xr, ONE);
    term = ONE;
    sum = 0;
    n = 0;
    for (int k = 1; k <= MAX_TERMS; k++) begin
      sum = sum + term;
      if (sum > smax) sum = smax;
      if (sum < -smax - 1) sum = -smax - 1;
      n = k;
      if (labs(term) < eps || k == MAX_TERMS) break;
      term = fdiv(-(fdiv(term * x2, ONE) * recip(k)), RSCALE);
    end
    c = sum;
    e = labs(term);
    if (e > (longint'(1) << DATA_W) - 1) e = (longint'(1) << DATA_W) - 1;
  endtask

  task automatic hold_cycles();
    int cnt, v;
    cnt = $urandom_range(0, 2);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      v = $urandom_range(0, 11);
      state = (v < 2) ? 4'(v) : 4'(v + 4);
      x_in = DATA_W'($urandom);
    end
  endtask

  task automatic run(input string tag, input longint x, input bit use_e0, input bit noise,
                     output longint c, output longint e, output int n);
    bit fin, d0, d1, d2;
    @(negedge clk);
    state = 4'd2;
    x_in = DATA_W'(x);
    fin = 1'b0;
    n = 0;
    for (int i = 0; i < 2*MAX_TERMS + 4 && !fin; i++) begin
      if (noise) hold_cycles();
      @(negedge clk);
      state = 4'd3;
      if (noise) x_in = DATA_W'($urandom);
      n++;
      if (use_e0 ? stop0 : stop) fin = 1'b1;
      else begin
        if (noise) hold_cycles();
        @(negedge clk);
        state = 4'd5;
      end
    end
    check({tag, "_stop_reached"}, longint'(fin), 1, 0);
    @(negedge clk);
    state = 4'd4;
    d0 = use_e0 ? done0 : done;
    @(negedge clk);
    state = 4'd0;
    d1 = use_e0 ? done0 : done;
    c = use_e0 ? longint'(cos0) : longint'(cos_out);
    e = use_e0 ? longint'(err0) : longint'(err_out);
    @(negedge clk);
    d2 = use_e0 ? done0 : done;
    check({tag, "_done_pulse"}, longint'({d0, d1, d2}), 3'b010, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint c, e, mc, me;
    int n, mn;
    logic signed [DATA_W-1:0] rx;

    rst = 1'b1;
    state = 4'd0;
    x_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cos", cos_out, 0, 0);
    check("rst_err", err_out, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_stop", stop, 1, 0);

    run("t1", 0, 1'b0, 1'b0, c, e, n);
    check("t1_terms", n, 2, 0);
    check("t1_cos", c, 32768, 0);
    check("t1_err", e, 0, 0);

    run("t2", 34315, 1'b0, 1'b0, c, e, n);
    model(34315, EPS, mc, me, mn);
    check("t2_cos_ideal", c, 16384, 4);
    check("t2_cos_model", c, mc, 0);
    check("t2_k_le6", longint'(n <= 6), 1, 0);

    run("t3", 102944, 1'b0, 1'b0, c, e, n);
    model(102944, EPS, mc, me, mn);
    check("t3_cos_ideal", c, -32768, 8);
    check("t3_cos_model", c, mc, 0);
    check("t3_err_model", e, me, 0);
    check("t3_terms", n, mn, 0);

    run("t4", 65536, 1'b1, 1'b0, c, e, n);
    model(65536, 0, mc, me, mn);
    check("t4_terms", n, MAX_TERMS, 0);
    check("t4_cos_model", c, mc, 0);

    @(negedge clk); state = 4'd2; x_in = DATA_W'(34315);
    @(negedge clk); state = 4'd3;
    @(negedge clk); state = 4'd5;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; state = 4'd3;
    check("t5_stop_after_rst", stop, 1, 0);
    @(negedge clk); state = 4'd4;
    @(negedge clk); state = 4'd0;
    check("t5_done", done, 1, 0);
    check("t5_cos", cos_out, 0, 0);
    check("t5_err", err_out, 0, 0);
    @(negedge clk);
    check("t5_done_clear", done, 0, 0);

    run("t6", -131072, 1'b0, 1'b0, c, e, n);
    model(-131072, EPS, mc, me, mn);
    check("t6_cos_model", c, mc, 0);
`ifdef RANGE_REDUCE_EN
    check("t6_cos_ideal", c, longint'($rtoi($cos(4.0) * real'(ONE))), 8);
`else
    check("t6_terms", n, MAX_TERMS, 0);
    check("t6_err_gt_eps", longint'(e > EPS), 1, 0);
`endif

    for (int i = 0; i < 12; i++) begin
      rx = DATA_W'($urandom);
      run("rnd", rx, 1'b0, 1'b1, c, e, n);
      model(rx, EPS, mc, me, mn);
      check("rnd_cos", c, mc, 0);
      check("rnd_err", e, me, 0);
      check("rnd_terms", n, mn, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
